gfx_scanout_fetch: RTL and testbench
====================================

# gfx_scanout_fetch

Sequencer that feeds the scanout pixel path. It walks the framebuffer in VRAM once per frame, issuing one read per `vram_word` (two words per pixel), and pushes the returned words, with mask bit 1, into the framebuffer/mask FIFO pair consumed by the scanout DAC stage. When fetching is disabled for a frame, it pushes the same number of mask-0 filler words instead, so the DAC emits clear color. The word stream and pixel timing stay unbroken in both cases. FIFO occupancy is tracked with credits, so the FIFO never overflows.

## Interface
Parameters:
- `X_RES`, default 640: pixels per line.
- `Y_RES`, default 480: lines per frame.
- `WORD_W`, default 16: width of `vram_word`.
- `ADDR_W`, default 24: VRAM word-address width.
- `FIFO_DEPTH`, default 16: entries in the fb/mask FIFO pair, which share one depth.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset. Synchronous and active-high.
- `enable_fetch`, in, 1: 1 means scan out the framebuffer; 0 means emit filler. Sampled only in START.
- `fb_base`, in, ADDR_W: framebuffer base word address. Sampled only in START.
- `mem_read`, out, 1: Avalon-MM read request.
- `mem_address`, out, ADDR_W: read word address.
- `mem_waitrequest`, in, 1: the slave stalls the request.
- `mem_readdatavalid`, in, 1: a read response is present.
- `mem_readdata`, in, WORD_W: read response data.
- `fifo_write`, out, 1: push one entry to both FIFOs.
- `fb_fifo_in`, out, WORD_W: word pushed to the fb FIFO.
- `mask_fifo_in`, out, 1: mask bit pushed to the mask FIFO.
- `fifo_pop`, in, 1: the consumer removed one entry this cycle (`in_ready && in_valid`).
- `frame_done`, out, 1: one-cycle pulse when the last word of a frame has been pushed.

## Operation
- The frame size is N = 2·X_RES·Y_RES words.
- Word index `idx` has width $clog2(N) and counts 0..N-1.
- States:
  - START: latch `base <= fb_base` and `mode <= enable_fetch`, and clear `idx`. Go to FETCH if `mode` is 1, else to FILL. START always lasts exactly 1 cycle.
  - FETCH:
    - Assert `mem_read` when `credit > 0`, with `mem_address = base + idx`, truncated to ADDR_W (wraps modulo 2^ADDR_W).
    - A read is accepted in a cycle with `mem_read && !mem_waitrequest`. On accept: `idx++` and `pending++`.
    - On accepting idx = N-1, go to DRAIN.
  - FILL:
    - When `credit > 0`, push `fb_fifo_in = 0` and `mask_fifo_in = 0`, then `idx++`.
    - On pushing idx = N-1, pulse `frame_done` and go to START.
  - DRAIN: issue no new requests. When `pending == 0` and no push is still in the output register, pulse `frame_done` and go to START.
- Response path, active in any state:
  - A cycle with `mem_readdatavalid` produces, on the next cycle, `fifo_write = 1`, `fb_fifo_in = mem_readdata`, `mask_fifo_in = 1`, and `pending--`.
  - FILL pushes never collide with response pushes, because FILL is entered only via START after `pending` has reached 0.
- Credits:
  - `credit` has width $clog2(FIFO_DEPTH+1) and resets to FIFO_DEPTH.
  - Decrement on a read accept or a FILL push. Increment on `fifo_pop`.
  - Decrement and increment in the same cycle leave `credit` unchanged.
  - Credit is reserved at issue time, so an outstanding read always has a FIFO slot.
- `fifo_pop` is counted regardless of state.
- `pending` width is $clog2(FIFO_DEPTH+1). It never exceeds FIFO_DEPTH.
- Once `mem_read` is asserted it stays asserted, with a stable `mem_address`, until accepted. It is never withdrawn while `mem_waitrequest` is high.
- The mode changes only at frame boundaries. Changes to `enable_fetch` or `fb_base` mid-frame have no effect until the next START.

## Timing
- Reset (synchronous, `rst = 1` at a clock edge) sets `mem_read = 0`, `mem_address = 0`, `fifo_write = 0`, `fb_fifo_in = 0`, `mask_fifo_in = 0`, `frame_done = 0`, `credit = FIFO_DEPTH`, `pending = 0`, `idx = 0`, state START.
- Reset mid-frame abandons the frame. Read responses arriving after reset are discarded; the system resets the memory slave alongside this block.
- The first cycle after reset is START. The first `mem_read` or FILL push comes in the following cycle.
- FETCH can accept one read per cycle while credit remains and `waitrequest` is low.
- `mem_readdatavalid` to `fifo_write` latency: 1 cycle.
- FILL pushes one word per cycle while `credit > 0`.
- `frame_done` pulses in the same cycle the block returns to START. Consecutive frames are separated by exactly one START cycle, plus the DRAIN time in fetch mode.
- `credit == 0` stalls issue. Requests resume in the cycle after the `fifo_pop` that restores the credit.

## Test plan
- Reset, then `enable_fetch = 1`, `fb_base = 0x1000`, X_RES = 4, Y_RES = 2, an always-ready slave returning `readdata = address[15:0]` after 3 cycles, and `fifo_pop` every cycle that the FIFO is non-empty → exactly 16 pushes, data 0x1000..0x100F in order, all with mask 1, then one `frame_done` pulse; the next frame restarts at 0x1000.
- Same setup but `fifo_pop` never asserted → exactly FIFO_DEPTH (16) reads are accepted, then `mem_read = 0` indefinitely. A single `fifo_pop` pulse → exactly one more read is accepted.
- `mem_waitrequest` held high for 5 cycles on the first request → `mem_read` stays 1 with `mem_address = 0x1000` for all 5 cycles; `idx` and `credit` are unchanged until the accept.
- `enable_fetch = 0` at START → N pushes with `fb_fifo_in = 0` and `mask_fifo_in = 0`, no `mem_read` at all, and `frame_done` after the Nth push.
- Toggle `enable_fetch` 1→0 mid-frame → the current frame completes in fetch mode, including DRAIN until `pending = 0`; the next frame is all filler, with no interleaving of mask-1 and mask-0 words.
- `fb_base = 2^ADDR_W − 2` → addresses wrap to 0 after 2 words. Assert `rst` mid-frame with 3 reads pending → outputs reach their reset values at the next edge, and late `readdatavalid` produces no `fifo_write`.

Source files
------------

// File: rtl/gfx_scanout_fetch.sv
`default_nettype none
// ============================================================================
// Module   : gfx_scanout_fetch
// Purpose  : Walks the framebuffer once per frame, issuing one VRAM read per
//            word (two words per pixel), and pushes the returned words with
//            mask 1 into the fb/mask FIFO pair. With fetching disabled it
//            pushes the same number of mask-0 filler words. FIFO space is
//            reserved with credits at issue time so the FIFO never overflows.
// Ports    : clk, rst                        - clock, sync active-high reset
//            enable_fetch, fb_base           - per-frame mode/base (START only)
//            mem_read/address/waitrequest,
//            mem_readdatavalid/readdata      - Avalon-MM read master
//            fifo_write, fb_fifo_in,
//            mask_fifo_in, fifo_pop          - FIFO pair push side + pop count
//            frame_done                      - pulse when a frame is complete
// Revision : 1.0 - initial release
// ============================================================================
module gfx_scanout_fetch #(
    parameter int X_RES      = 640,
    parameter int Y_RES      = 480,
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_fetch,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    input  logic              mem_waitrequest,
    input  logic              mem_readdatavalid,
    input  logic [WORD_W-1:0] mem_readdata,
    output logic              fifo_write,
    output logic [WORD_W-1:0] fb_fifo_in,
    output logic              mask_fifo_in,
    input  logic              fifo_pop,
    output logic              frame_done
);

    localparam int c_frame_words = 2 * X_RES * Y_RES;
    localparam int c_idx_w       = $clog2(c_frame_words);
    localparam int c_cred_w      = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_idx_w-1:0]  c_last_idx    = c_idx_w'(c_frame_words - 1);
    localparam logic [c_idx_w-1:0]  c_idx_one     = c_idx_w'(1);
    localparam logic [c_cred_w-1:0] c_full_credit = c_cred_w'(FIFO_DEPTH);
    localparam logic [c_cred_w-1:0] c_cred_one    = c_cred_w'(1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_FILL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [c_idx_w-1:0]  idx_q, idx_d;
    logic [c_cred_w-1:0] credit_q, credit_d;
    logic [c_cred_w-1:0] pending_q, pending_d;
    logic                resp_valid_q;
    logic [WORD_W-1:0]   resp_data_q;

    logic w_has_credit;
    logic w_accept;
    logic w_fill_push;
    logic w_resp_take;

    assign w_has_credit = (credit_q != '0);

    // Responses are only taken while reads are outstanding; anything that
    // arrives with nothing pending belongs to a frame abandoned by reset.
    assign w_resp_take = mem_readdatavalid && (pending_q != '0);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        idx_d       = idx_q;
        mem_read    = 1'b0;
        w_accept    = 1'b0;
        w_fill_push = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            ST_START: begin
                base_d  = fb_base;
                idx_d   = '0;
                state_d = enable_fetch ? ST_FETCH : ST_FILL;
            end
            ST_FETCH: begin
                // Credit can only grow while a request waits, so once raised
                // mem_read holds with a stable address until accepted.
                mem_read = w_has_credit;
                w_accept = w_has_credit && !mem_waitrequest;
                if (w_accept) begin
                    idx_d = idx_q + c_idx_one;
                    if (idx_q == c_last_idx) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_FILL: begin
                if (w_has_credit) begin
                    w_fill_push = 1'b1;
                    idx_d       = idx_q + c_idx_one;
                    if (idx_q == c_last_idx) begin
                        frame_done = 1'b1;
                        state_d    = ST_START;
                    end
                end
            end
            ST_DRAIN: begin
                if ((pending_q == '0) && !resp_valid_q) begin
                    frame_done = 1'b1;
                    state_d    = ST_START;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    // Credit is spent at issue (read accept or filler push), returned on pop.
    always_comb begin
        credit_d = credit_q;
        case ({w_accept || w_fill_push, fifo_pop})
            2'b10:   credit_d = credit_q - c_cred_one;
            2'b01:   credit_d = credit_q + c_cred_one;
            default: credit_d = credit_q;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        case ({w_accept, w_resp_take})
            2'b10:   pending_d = pending_q + c_cred_one;
            2'b01:   pending_d = pending_q - c_cred_one;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_START;
            base_q       <= '0;
            idx_q        <= '0;
            credit_q     <= c_full_credit;
            pending_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            credit_q     <= credit_d;
            pending_q    <= pending_d;
            resp_valid_q <= w_resp_take;
            if (w_resp_take) begin
                resp_data_q <= mem_readdata;
            end
        end
    end

    // Address wraps modulo 2^ADDR_W by truncation.
    assign mem_address  = base_q + ADDR_W'(idx_q);

    // Filler pushes only happen in FILL, entered after pending drained, so a
    // response push and a filler push never share a cycle.
    assign fifo_write   = resp_valid_q || w_fill_push;
    assign fb_fifo_in   = resp_valid_q ? resp_data_q : '0;
    assign mask_fifo_in = resp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_gfx_scanout_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_gfx_scanout_fetch
// Purpose  : Directed self-checking bench for gfx_scanout_fetch with a
//            4x2 frame (16 words), an Avalon slave answering address[15:0]
//            three cycles after accept, and a FIFO occupancy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gfx_scanout_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_fetch = 1'b1;
    logic [23:0] fb_base = 24'h001000;
    logic        mem_read;
    logic [23:0] mem_address;
    logic        mem_waitrequest = 1'b0;
    logic        mem_readdatavalid = 1'b0;
    logic [15:0] mem_readdata = 16'h0;
    logic        fifo_write;
    logic [15:0] fb_fifo_in;
    logic        mask_fifo_in;
    logic        fifo_pop = 1'b0;
    logic        frame_done;

    gfx_scanout_fetch #(
        .X_RES(4), .Y_RES(2), .WORD_W(16), .ADDR_W(24), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst), .enable_fetch(enable_fetch), .fb_base(fb_base),
        .mem_read(mem_read), .mem_address(mem_address),
        .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
        .mem_readdata(mem_readdata), .fifo_write(fifo_write),
        .fb_fifo_in(fb_fifo_in), .mask_fifo_in(mask_fifo_in),
        .fifo_pop(fifo_pop), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;
        int          due;
    } rd_t;

    rd_t         rq[$];
    rd_t         rd_e;
    logic [23:0] acc_addr[$];
    int          acc_cyc[$];
    logic [15:0] push_data[$];
    logic        push_mask[$];
    int          done_push[$];
    int          done_cnt = 0;
    int          cyc = 0;
    int          fifo_cnt = 0;
    int          pop_cyc = -1;
    int          wait_used = 0;
    int          wait_limit = 0;
    int          pop_used = 0;
    int          pop_reqs = 0;
    bit          pop_en = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int p0, a0, d0, dp0;

    // Slave, consumer and log model; inputs change mid-cycle for the next edge.
    always @(negedge clk) begin
        mem_waitrequest = mem_read && (wait_used < wait_limit);
        if (mem_waitrequest) wait_used = wait_used + 1;
        mem_readdatavalid = 1'b0;
        mem_readdata      = 16'h0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = rq[0].addr[15:0];
            void'(rq.pop_front());
        end
        fifo_pop = 1'b0;
        if (!rst && fifo_cnt > 0) begin
            if (pop_en) begin
                fifo_pop = 1'b1;
            end else if (pop_used < pop_reqs) begin
                fifo_pop = 1'b1;
                pop_used = pop_used + 1;
                pop_cyc  = cyc;
            end
        end
        if (mem_read && !mem_waitrequest) begin
            rd_e.addr = mem_address;
            rd_e.due  = cyc + 3;
            rq.push_back(rd_e);
            acc_addr.push_back(mem_address);
            acc_cyc.push_back(cyc);
        end
        if (fifo_write) begin
            push_data.push_back(fb_fifo_in);
            push_mask.push_back(mask_fifo_in);
        end
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_push.push_back(push_data.size());
        end
        fifo_cnt = fifo_cnt + int'(fifo_write) - int'(fifo_pop);
        if (rst) fifo_cnt = 0;
        cyc = cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic en, input logic [23:0] base, input bit pop);
        rst = 1'b1; enable_fetch = en; fb_base = base; pop_en = pop;
        step();
        step();
        for (int i = 0; i < 20 && rq.size() > 0; i++) step();
        p0 = push_data.size(); a0 = acc_addr.size();
        d0 = done_cnt; dp0 = done_push.size();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound);
        int n;
        n = 0;
        while (done_cnt < target && n < bound) begin step(); n++; end
        n_tests++;
        if (done_cnt < target) begin
            n_fail++;
            $display("FAIL frame_done_timeout: got %0d frames, need %0d", done_cnt - d0, target - d0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_tests++;
        if ({mem_read, fifo_write, mask_fifo_in, frame_done} !== 4'b0000 ||
            mem_address !== 24'h0 || fb_fifo_in !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: rd=%b addr=%h wr=%b data=%h mask=%b done=%b, need all 0",
                     mem_read, mem_address, fifo_write, fb_fifo_in, mask_fifo_in, frame_done);
        end
        do_reset(1'b1, 24'h001000, 1'b1);
        n_tests++;
        if (mem_read !== 1'b0) begin
            n_fail++; $display("FAIL start_cycle_read: mem_read=%b, need 0", mem_read);
        end
        step();
        n_tests++;
        if (mem_read !== 1'b1 || mem_address !== 24'h001000) begin
            n_fail++;
            $display("FAIL first_request: rd=%b addr=%h, need 1 001000", mem_read, mem_address);
        end
    endtask

    task automatic test_fetch_frame();
        int n;
        wait_done(d0 + 1, 300);
        if (done_cnt > d0) begin
            n_tests++;
            if (done_push[dp0] - p0 !== 16) begin
                n_fail++; $display("FAIL fetch_push_count: got %0d, need 16", done_push[dp0] - p0);
            end
            for (int i = 0; i < 16 && p0 + i < push_data.size(); i++) begin
                n_tests++;
                if (push_data[p0+i] !== 16'h1000 + 16'(i) || push_mask[p0+i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fetch_word%0d: data=%h mask=%b, need %h 1",
                             i, push_data[p0+i], push_mask[p0+i], 16'h1000 + 16'(i));
                end
            end
        end
        n = 0;
        while (acc_addr.size() < a0 + 17 && n < 60) begin step(); n++; end
        n_tests++;
        if (acc_addr.size() < a0 + 17 || acc_addr[a0+16] !== 24'h001000) begin
            n_fail++;
            $display("FAIL next_frame_restart: accepts=%0d, need 17 with addr 001000", acc_addr.size() - a0);
        end
    endtask

    task automatic test_credit();
        do_reset(1'b1, 24'h001000, 1'b0);
        repeat (60) step();
        n_tests++;
        if (acc_addr.size() - a0 !== 16 || mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_stall: accepts=%0d rd=%b, need 16 0", acc_addr.size() - a0, mem_read);
        end
        n_tests++;
        if (push_data.size() - p0 !== 16) begin
            n_fail++; $display("FAIL credit_pushes: got %0d, need 16", push_data.size() - p0);
        end
        pop_reqs = pop_reqs + 1;
        repeat (20) step();
        n_tests++;
        if (acc_addr.size() - a0 !== 17 || mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_one_pop: accepts=%0d rd=%b, need 17 0", acc_addr.size() - a0, mem_read);
        end else if (acc_cyc[a0+16] !== pop_cyc + 1) begin
            n_tests++;
            n_fail++;
            $display("FAIL credit_resume_time: accept cyc %0d, need %0d", acc_cyc[a0+16], pop_cyc + 1);
        end
    endtask

    task automatic test_waitrequest();
        wait_limit = wait_used + 5;
        do_reset(1'b1, 24'h001000, 1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (mem_read !== 1'b1 || mem_address !== 24'h001000 || acc_addr.size() !== a0) begin
                n_fail++;
                $display("FAIL wait_hold%0d: rd=%b addr=%h accepts=%0d, need 1 001000 0",
                         i, mem_read, mem_address, acc_addr.size() - a0);
            end
            step();
        end
        step();
        n_tests++;
        if (acc_addr.size() !== a0 + 1 || mem_address !== 24'h001001) begin
            n_fail++;
            $display("FAIL wait_release: accepts=%0d addr=%h, need 1 001001", acc_addr.size() - a0, mem_address);
        end
    endtask

    task automatic test_fill();
        do_reset(1'b0, 24'h001000, 1'b1);
        step();
        n_tests++;
        if (fifo_write !== 1'b1 || fb_fifo_in !== 16'h0 || mask_fifo_in !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_first_push: wr=%b data=%h mask=%b, need 1 0000 0", fifo_write, fb_fifo_in, mask_fifo_in);
        end
        wait_done(d0 + 1, 100);
        if (done_cnt > d0) begin
            n_tests++;
            if (done_push[dp0] - p0 !== 16 || acc_addr.size() !== a0) begin
                n_fail++;
                $display("FAIL fill_counts: pushes=%0d reads=%0d, need 16 0", done_push[dp0] - p0, acc_addr.size() - a0);
            end
            for (int i = 0; i < 16; i++) begin
                n_tests++;
                if (push_data[p0+i] !== 16'h0 || push_mask[p0+i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_word%0d: data=%h mask=%b, need 0000 0", i, push_data[p0+i], push_mask[p0+i]);
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        int n;
        do_reset(1'b1, 24'h002000, 1'b1);
        n = 0;
        while (acc_addr.size() < a0 + 5 && n < 40) begin step(); n++; end
        enable_fetch = 1'b0;
        fb_base = 24'h003000;
        wait_done(d0 + 2, 300);
        if (done_cnt >= d0 + 2) begin
            n_tests++;
            if (done_push[dp0] - p0 !== 16 || done_push[dp0+1] - p0 !== 32 || acc_addr.size() - a0 !== 16) begin
                n_fail++;
                $display("FAIL switch_counts: f1=%0d f2=%0d reads=%0d, need 16 32 16",
                         done_push[dp0] - p0, done_push[dp0+1] - p0, acc_addr.size() - a0);
            end
            for (int i = 0; i < 32; i++) begin
                n_tests++;
                if (i < 16 && (push_data[p0+i] !== 16'h2000 + 16'(i) || push_mask[p0+i] !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL switch_fetch_word%0d: data=%h mask=%b, need %h 1",
                             i, push_data[p0+i], push_mask[p0+i], 16'h2000 + 16'(i));
                end else if (i >= 16 && (push_data[p0+i] !== 16'h0 || push_mask[p0+i] !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL switch_fill_word%0d: data=%h mask=%b, need 0000 0", i, push_data[p0+i], push_mask[p0+i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        logic [23:0] exp_a[4];
        exp_a[0] = 24'hFFFFFE; exp_a[1] = 24'hFFFFFF; exp_a[2] = 24'h000000; exp_a[3] = 24'h000001;
        do_reset(1'b1, 24'hFFFFFE, 1'b1);
        n = 0;
        while ((acc_addr.size() < a0 + 4 || push_data.size() < p0 + 4) && n < 40) begin step(); n++; end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (acc_addr.size() < a0 + 4 || push_data.size() < p0 + 4) begin
                n_fail++; $display("FAIL wrap_timeout%0d: too few reads/pushes", i);
            end else if (acc_addr[a0+i] !== exp_a[i] || push_data[p0+i] !== exp_a[i][15:0]) begin
                n_fail++;
                $display("FAIL wrap_word%0d: addr=%h data=%h, need %h %h",
                         i, acc_addr[a0+i], push_data[p0+i], exp_a[i], exp_a[i][15:0]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int n, p1, a1;
        do_reset(1'b1, 24'h004000, 1'b1);
        n = 0;
        while ((rq.size() != 3 || acc_addr.size() < a0 + 3) && n < 40) begin step(); n++; end
        rst = 1'b1;
        wait_limit = wait_used + 4;
        step();
        rst = 1'b0;
        n_tests++;
        if ({mem_read, fifo_write, mask_fifo_in, frame_done} !== 4'b0000 ||
            mem_address !== 24'h0 || fb_fifo_in !== 16'h0) begin
            n_fail++;
            $display("FAIL midframe_reset: rd=%b addr=%h wr=%b data=%h mask=%b done=%b, need all 0",
                     mem_read, mem_address, fifo_write, fb_fifo_in, mask_fifo_in, frame_done);
        end
        p1 = push_data.size();
        a1 = acc_addr.size();
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (fifo_write !== 1'b0) begin
                n_fail++; $display("FAIL late_response%0d: fifo_write=%b data=%h, need 0", i, fifo_write, fb_fifo_in);
            end
        end
        n = 0;
        while (push_data.size() < p1 + 1 && n < 40) begin step(); n++; end
        n_tests++;
        if (push_data.size() < p1 + 1 || acc_addr.size() < a1 + 1 ||
            acc_addr[a1] !== 24'h004000 || push_data[p1] !== 16'h4000) begin
            n_fail++;
            $display("FAIL post_reset_frame: pushes=%0d, need first addr 004000 data 4000", push_data.size() - p1);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_frame();
        test_credit();
        test_waitrequest();
        test_fill();
        test_mode_switch();
        test_wrap();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
